// File: rtl/sl_bridge_pkg.sv
// Shared definitions for the multi-channel FIFO-to-transceiver bridge.
// Holds the command modifier codes, response frame field positions, the
// state encodings of both bridge FSMs and the response frame builder.
package sl_bridge_pkg;

  localparam int FRAME_W = 34;
  localparam int HMB     = 33;
  localparam int LMB     = 32;
  localparam int CH_LSB  = 16;

  typedef enum logic [1:0] {
    MOD_CONFIG  = 2'd0,
    MOD_DATA    = 2'd1,
    MOD_STATUS  = 2'd2,
    MOD_CHANNEL = 2'd3
  } mod_e;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_EXEC = 2'd1, W_GAP = 2'd2} wstate_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_PUSH = 2'd1, R_PUSH2 = 2'd2} rstate_e;

  // Action decided in W_IDLE and carried out (with the pop) in W_EXEC.
  typedef enum logic [2:0] {
    OP_CHAN, OP_CHAN_BAD, OP_ERR, OP_CFG_TX, OP_CFG_RX, OP_DATA_TX
  } op_e;

  // Which pending source the read side has latched for its next frame.
  typedef enum logic [1:0] {K_CHAN, K_CFG, K_ST} kind_e;

  function automatic logic [FRAME_W-1:0] make_frame(input mod_e m,
                                                    input logic [15:0] ch,
                                                    input logic [15:0] val);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[HMB:LMB] = m;
    f[LMB-1:CH_LSB] = ch;
    f[CH_LSB-1:0] = val;
    return f;
  endfunction

endpackage

// File: rtl/sl_rr_arbiter.sv
// Round-robin arbiter.
//   req     : N request lines
//   accept  : the current grant has been taken; pointer moves past it
//   gnt     : one-hot grant, gnt_idx its index, gnt_vld any request present
// Search starts at ptr_q and wraps at N; ptr_q is the index after the last
// accepted grant.
module sl_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             accept,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    // Walk backwards so the request closest to the pointer is written last.
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && gnt_vld)
      ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sl_fifo_bridge_mc.sv
// Multi-channel FIFO-to-transceiver register bridge.
// Inbound : fifo_read_* (show-ahead, 34-bit {modifier, payload}); one
//           command every 3 cycles through W_IDLE -> W_EXEC -> W_GAP.
// TX side : wr_data_tx/data_we_tx, wr_config_tx/config_we_tx (one-hot),
//           rd_status_tx (busy), rd_config_tx, change pulses.
// RX side : wr_config_rx/config_we_rx (one-hot), rd_status_rx, rd_config_rx,
//           rd_data_rx (16-bit lanes), change pulses.
// Outbound: fifo_write_* response frames {modifier, channel index, value}.
// channel : selected channel register; err_cnt: saturating error count.
module sl_fifo_bridge_mc
  import sl_bridge_pkg::*;
#(
  parameter int TX_COUNT = 2,
  parameter int RX_COUNT = 2,
  parameter int CH_W     = 5,
  parameter int ERR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_read_empty,
  input  logic [33:0]            fifo_read_data,
  output logic                   fifo_read_inc,
  input  logic                   fifo_write_full,
  output logic [33:0]            fifo_write_data,
  output logic                   fifo_write_inc,
  output logic [31:0]            wr_data_tx,
  output logic [TX_COUNT-1:0]    data_we_tx,
  output logic [15:0]            wr_config_tx,
  output logic [TX_COUNT-1:0]    config_we_tx,
  input  logic [TX_COUNT-1:0]    rd_status_tx,
  input  logic [16*TX_COUNT-1:0] rd_config_tx,
  input  logic [TX_COUNT-1:0]    config_changed_tx,
  input  logic [TX_COUNT-1:0]    status_changed_tx,
  output logic [15:0]            wr_config_rx,
  output logic [RX_COUNT-1:0]    config_we_rx,
  input  logic [16*RX_COUNT-1:0] rd_status_rx,
  input  logic [16*RX_COUNT-1:0] rd_config_rx,
  input  logic [16*RX_COUNT-1:0] rd_data_rx,
  input  logic [RX_COUNT-1:0]    config_changed_rx,
  input  logic [RX_COUNT-1:0]    data_status_changed_rx,
  output logic [CH_W-1:0]        channel,
  output logic [ERR_W-1:0]       err_cnt
);

  localparam int NCH   = TX_COUNT + RX_COUNT;
  localparam int NSLOT = 2 ** CH_W;

  wstate_e          wstate_q, wstate_d;
  op_e              op_q, op_d;
  logic [CH_W-1:0]  channel_q, channel_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             chan_pend_q, chan_pend_d;
  logic [NCH-1:0]   cfg_p_q, cfg_p_d, st_p_q, st_p_d;
  rstate_e          rstate_q, rstate_d;
  logic [CH_W-1:0]  sel_q, sel_d;
  kind_e            kind_q, kind_d;

  logic             chan_set, chan_clr, cfg_clr_en, st_clr_en, arb_accept;
  logic [NCH-1:0]   arb_gnt;
  logic [CH_W-1:0]  arb_idx;
  logic             arb_vld;

  logic [31:0]      payload;
  mod_e             cmd_mod;
  logic             chan_is_tx, sel_is_tx;

  // Per-slot views of the packed lanes, padded to the full index range so
  // any channel/sel value indexes them safely.
  logic [NSLOT-1:0] busy_all;
  logic [15:0]      cfg_lane  [NSLOT];
  logic [15:0]      st_lane   [NSLOT];
  logic [15:0]      data_lane [NSLOT];

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign payload    = fifo_read_data[31:0];
  assign cmd_mod    = mod_e'(fifo_read_data[HMB:LMB]);
  assign chan_is_tx = int'(channel_q) < TX_COUNT;
  assign sel_is_tx  = int'(sel_q) < TX_COUNT;
  assign channel    = channel_q;
  assign err_cnt    = err_q;

  always_comb begin
    busy_all = '0;
    for (int i = 0; i < NSLOT; i++) begin
      cfg_lane[i]  = '0;
      st_lane[i]   = '0;
      data_lane[i] = '0;
    end
    for (int i = 0; i < TX_COUNT; i++) begin
      busy_all[i] = rd_status_tx[i];
      cfg_lane[i] = rd_config_tx[16*i +: 16];
      st_lane[i]  = {15'b0, rd_status_tx[i]};
    end
    for (int i = 0; i < RX_COUNT; i++) begin
      busy_all[TX_COUNT+i]  = rd_status_rx[16*i];
      cfg_lane[TX_COUNT+i]  = rd_config_rx[16*i +: 16];
      st_lane[TX_COUNT+i]   = rd_status_rx[16*i +: 16];
      data_lane[TX_COUNT+i] = rd_data_rx[16*i +: 16];
    end
  end

  // Write side: decode in W_IDLE, act and pop in W_EXEC, W_GAP lets the
  // FIFO's empty flag catch up so the next word is never popped twice.
  always_comb begin
    wstate_d      = wstate_q;
    op_d          = op_q;
    channel_d     = channel_q;
    err_d         = err_q;
    chan_set      = 1'b0;
    fifo_read_inc = 1'b0;
    wr_data_tx    = '0;
    data_we_tx    = '0;
    wr_config_tx  = '0;
    config_we_tx  = '0;
    wr_config_rx  = '0;
    config_we_rx  = '0;
    case (wstate_q)
      W_IDLE: begin
        if (!fifo_read_empty) begin
          if (cmd_mod == MOD_CHANNEL) begin
            op_d     = (payload < 32'(NCH)) ? OP_CHAN : OP_CHAN_BAD;
            wstate_d = W_EXEC;
          end else if (!busy_all[channel_q]) begin
            wstate_d = W_EXEC;
            if (cmd_mod == MOD_CONFIG)                 op_d = chan_is_tx ? OP_CFG_TX : OP_CFG_RX;
            else if (cmd_mod == MOD_DATA && chan_is_tx) op_d = OP_DATA_TX;
            else                                        op_d = OP_ERR;
          end
        end
      end
      W_EXEC: begin
        fifo_read_inc = 1'b1;
        wstate_d      = W_GAP;
        case (op_q)
          OP_CHAN: begin
            channel_d = payload[CH_W-1:0];
            chan_set  = 1'b1;
          end
          OP_CHAN_BAD: begin
            err_d    = sat_inc(err_q);
            chan_set = 1'b1;
          end
          OP_ERR: err_d = sat_inc(err_q);
          OP_CFG_TX: begin
            wr_config_tx = payload[15:0];
            for (int i = 0; i < TX_COUNT; i++) config_we_tx[i] = (int'(channel_q) == i);
          end
          OP_CFG_RX: begin
            wr_config_rx = payload[15:0];
            for (int i = 0; i < RX_COUNT; i++) config_we_rx[i] = (int'(channel_q) == TX_COUNT + i);
          end
          OP_DATA_TX: begin
            wr_data_tx = payload;
            for (int i = 0; i < TX_COUNT; i++) data_we_tx[i] = (int'(channel_q) == i);
          end
          default: ;
        endcase
      end
      W_GAP:   wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read side: pick a source in R_IDLE, push it in R_PUSH. RX status events
  // need two frames (data then status), the second from R_PUSH2.
  always_comb begin
    rstate_d        = rstate_q;
    sel_d           = sel_q;
    kind_d          = kind_q;
    arb_accept      = 1'b0;
    chan_clr        = 1'b0;
    cfg_clr_en      = 1'b0;
    st_clr_en       = 1'b0;
    fifo_write_inc  = 1'b0;
    fifo_write_data = '0;
    case (rstate_q)
      R_IDLE: begin
        if (!fifo_write_full) begin
          if (chan_pend_q) begin
            kind_d   = K_CHAN;
            rstate_d = R_PUSH;
          end else if (arb_vld) begin
            sel_d      = arb_idx;
            kind_d     = (|(arb_gnt & cfg_p_q)) ? K_CFG : K_ST;
            arb_accept = 1'b1;
            rstate_d   = R_PUSH;
          end
        end
      end
      R_PUSH: begin
        if (!fifo_write_full) begin
          fifo_write_inc = 1'b1;
          rstate_d       = R_IDLE;
          case (kind_q)
            K_CHAN: begin
              fifo_write_data = make_frame(MOD_CHANNEL, 16'(channel_q), 16'(channel_q));
              chan_clr        = 1'b1;
            end
            K_CFG: begin
              fifo_write_data = make_frame(MOD_CONFIG, 16'(sel_q), cfg_lane[sel_q]);
              cfg_clr_en      = 1'b1;
            end
            default: begin
              st_clr_en = 1'b1;
              if (sel_is_tx) begin
                fifo_write_data = make_frame(MOD_STATUS, 16'(sel_q), st_lane[sel_q]);
              end else begin
                fifo_write_data = make_frame(MOD_DATA, 16'(sel_q), data_lane[sel_q]);
                rstate_d        = R_PUSH2;
              end
            end
          endcase
        end
      end
      R_PUSH2: begin
        if (!fifo_write_full) begin
          fifo_write_inc  = 1'b1;
          fifo_write_data = make_frame(MOD_STATUS, 16'(sel_q), st_lane[sel_q]);
          rstate_d        = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Sticky event flags: a new pulse wins over a clear in the same cycle.
  always_comb begin
    chan_pend_d = (chan_pend_q & ~chan_clr) | chan_set;
    cfg_p_d     = cfg_p_q | {config_changed_rx, config_changed_tx};
    st_p_d      = st_p_q  | {data_status_changed_rx, status_changed_tx};
    for (int i = 0; i < NCH; i++) begin
      if (cfg_clr_en && int'(sel_q) == i) cfg_p_d[i] = cfg_p_d[i] & ~cfg_p_q[i] | (i < TX_COUNT ? config_changed_tx[i % TX_COUNT] : config_changed_rx[(i - TX_COUNT) % RX_COUNT]);
      if (st_clr_en && int'(sel_q) == i)  st_p_d[i]  = (i < TX_COUNT) ? status_changed_tx[i % TX_COUNT] : data_status_changed_rx[(i - TX_COUNT) % RX_COUNT];
    end
  end

  sl_rr_arbiter #(.N(NCH), .IDX_W(CH_W)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (cfg_p_q | st_p_q),
    .accept  (arb_accept),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q    <= W_IDLE;
      op_q        <= OP_ERR;
      channel_q   <= '0;
      err_q       <= '0;
      chan_pend_q <= 1'b0;
      cfg_p_q     <= '0;
      st_p_q      <= '0;
      rstate_q    <= R_IDLE;
      sel_q       <= '0;
      kind_q      <= K_CHAN;
    end else begin
      wstate_q    <= wstate_d;
      op_q        <= op_d;
      channel_q   <= channel_d;
      err_q       <= err_d;
      chan_pend_q <= chan_pend_d;
      cfg_p_q     <= cfg_p_d;
      st_p_q      <= st_p_d;
      rstate_q    <= rstate_d;
      sel_q       <= sel_d;
      kind_q      <= kind_d;
    end
  end

endmodule

// File: tb/tb_sl_fifo_bridge_mc.sv
// Directed bench for sl_fifo_bridge_mc (TX_COUNT=2, RX_COUNT=2).
// Models the inbound show-ahead FIFO and the outbound FIFO as queues.
module tb_sl_fifo_bridge_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_read_empty;
  logic [33:0] fifo_read_data;
  logic        fifo_read_inc;
  logic        fifo_write_full;
  logic [33:0] fifo_write_data;
  logic        fifo_write_inc;
  logic [31:0] wr_data_tx;
  logic [1:0]  data_we_tx;
  logic [15:0] wr_config_tx;
  logic [1:0]  config_we_tx;
  logic [1:0]  rd_status_tx;
  logic [31:0] rd_config_tx;
  logic [1:0]  config_changed_tx, status_changed_tx;
  logic [15:0] wr_config_rx;
  logic [1:0]  config_we_rx;
  logic [31:0] rd_status_rx, rd_config_rx, rd_data_rx;
  logic [1:0]  config_changed_rx, data_status_changed_rx;
  logic [4:0]  channel;
  logic [7:0]  err_cnt;

  sl_fifo_bridge_mc #(.TX_COUNT(2), .RX_COUNT(2), .CH_W(5), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_read_empty(fifo_read_empty), .fifo_read_data(fifo_read_data), .fifo_read_inc(fifo_read_inc),
    .fifo_write_full(fifo_write_full), .fifo_write_data(fifo_write_data), .fifo_write_inc(fifo_write_inc),
    .wr_data_tx(wr_data_tx), .data_we_tx(data_we_tx), .wr_config_tx(wr_config_tx), .config_we_tx(config_we_tx),
    .rd_status_tx(rd_status_tx), .rd_config_tx(rd_config_tx),
    .config_changed_tx(config_changed_tx), .status_changed_tx(status_changed_tx),
    .wr_config_rx(wr_config_rx), .config_we_rx(config_we_rx),
    .rd_status_rx(rd_status_rx), .rd_config_rx(rd_config_rx), .rd_data_rx(rd_data_rx),
    .config_changed_rx(config_changed_rx), .data_status_changed_rx(data_status_changed_rx),
    .channel(channel), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [33:0] inq[$];
  logic [33:0] outq[$];
  int          n_pops, n_we, n_full_push;
  logic [1:0]  acc_cwtx, acc_cwrx, acc_dwtx;
  logic [31:0] cap_bus;
  logic        pop_now = 1'b0, push_now = 1'b0;
  logic [33:0] push_word;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [1:0]  mod;
    logic [31:0] pay;
    logic [4:0]  e_ch;
    logic [1:0]  e_cwtx, e_cwrx, e_dwtx;
    int          e_nwe;
    logic [31:0] e_bus;
    logic [7:0]  e_err;
    int          e_nfr;
    logic [33:0] e_fr;
  } vec_t;
  vec_t vecs[14];

  task automatic refresh();
    fifo_read_empty = (inq.size() == 0);
    fifo_read_data  = (inq.size() == 0) ? 34'h0 : inq[0];
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // DUT outputs are sampled mid-cycle; FIFO state moves just after the edge.
  always @(negedge clk) begin
    pop_now   = fifo_read_inc;
    push_now  = fifo_write_inc;
    push_word = fifo_write_data;
    if (fifo_write_inc && fifo_write_full) n_full_push++;
    acc_cwtx |= config_we_tx;
    acc_cwrx |= config_we_rx;
    acc_dwtx |= data_we_tx;
    if (|config_we_tx || |config_we_rx || |data_we_tx) n_we++;
    if (|config_we_tx) cap_bus = {16'h0, wr_config_tx};
    if (|config_we_rx) cap_bus = {16'h0, wr_config_rx};
    if (|data_we_tx)   cap_bus = wr_data_tx;
  end

  always @(posedge clk) begin
    #1;
    if (pop_now) begin
      if (inq.size() > 0) void'(inq.pop_front());
      n_pops++;
      pop_now = 1'b0;
    end
    if (push_now) begin
      outq.push_back(push_word);
      push_now = 1'b0;
    end
    refresh();
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    n_pops = 0; n_we = 0; n_full_push = 0;
    acc_cwtx = '0; acc_cwrx = '0; acc_dwtx = '0; cap_bus = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_write_full = 1'b0;
    rd_status_tx = '0; rd_config_tx = '0;
    config_changed_tx = '0; status_changed_tx = '0;
    rd_status_rx = '0; rd_config_rx = '0; rd_data_rx = '0;
    config_changed_rx = '0; data_status_changed_rx = '0;
    inq.delete(); outq.delete(); refresh();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clr_mon();
  endtask

  task automatic push_in(input logic [1:0] m, input logic [31:0] p);
    inq.push_back({m, p});
    refresh();
  endtask

  task automatic run_vec(input vec_t v, input int k);
    clr_mon();
    outq.delete();
    push_in(v.mod, v.pay);
    repeat (8) tick();
    chk($sformatf("v%0d pops", k), n_pops, 1);
    chk($sformatf("v%0d cfg_we_tx", k), acc_cwtx, v.e_cwtx);
    chk($sformatf("v%0d cfg_we_rx", k), acc_cwrx, v.e_cwrx);
    chk($sformatf("v%0d data_we_tx", k), acc_dwtx, v.e_dwtx);
    chk($sformatf("v%0d we_cycles", k), n_we, v.e_nwe);
    chk($sformatf("v%0d bus", k), cap_bus, v.e_bus);
    chk($sformatf("v%0d channel", k), channel, v.e_ch);
    chk($sformatf("v%0d err_cnt", k), err_cnt, v.e_err);
    chk($sformatf("v%0d frames", k), outq.size(), v.e_nfr);
    if (v.e_nfr > 0 && outq.size() > 0) chk($sformatf("v%0d frame", k), outq[0], v.e_fr);
  endtask

  task automatic pulse(input logic [1:0] ctx, input logic [1:0] stx,
                       input logic [1:0] crx, input logic [1:0] srx);
    config_changed_tx = ctx; status_changed_tx = stx;
    config_changed_rx = crx; data_status_changed_rx = srx;
    tick();
    config_changed_tx = '0; status_changed_tx = '0;
    config_changed_rx = '0; data_status_changed_rx = '0;
  endtask

  initial begin
    logic got;
    //          mod    payload        ch  cwtx  cwrx  dwtx  nwe bus            err nfr frame
    vecs[0]  = '{2'd3, 32'd3,          3, 2'b00, 2'b00, 2'b00, 0, 32'h0,        0, 1, 34'h3_0003_0003};
    vecs[1]  = '{2'd3, 32'd1,          1, 2'b00, 2'b00, 2'b00, 0, 32'h0,        0, 1, 34'h3_0001_0001};
    vecs[2]  = '{2'd0, 32'h1234_A5A5,  1, 2'b10, 2'b00, 2'b00, 1, 32'h0000_A5A5, 0, 0, 34'h0};
    vecs[3]  = '{2'd1, 32'hDEAD_BEEF,  1, 2'b00, 2'b00, 2'b10, 1, 32'hDEAD_BEEF, 0, 0, 34'h0};
    vecs[4]  = '{2'd2, 32'h0,          1, 2'b00, 2'b00, 2'b00, 0, 32'h0,        1, 0, 34'h0};
    vecs[5]  = '{2'd3, 32'd2,          2, 2'b00, 2'b00, 2'b00, 0, 32'h0,        1, 1, 34'h3_0002_0002};
    vecs[6]  = '{2'd0, 32'h0000_5A5A,  2, 2'b00, 2'b01, 2'b00, 1, 32'h0000_5A5A, 1, 0, 34'h0};
    vecs[7]  = '{2'd1, 32'h1,          2, 2'b00, 2'b00, 2'b00, 0, 32'h0,        2, 0, 34'h0};
    vecs[8]  = '{2'd3, 32'd9,          2, 2'b00, 2'b00, 2'b00, 0, 32'h0,        3, 1, 34'h3_0002_0002};
    vecs[9]  = '{2'd3, 32'd3,          3, 2'b00, 2'b00, 2'b00, 0, 32'h0,        3, 1, 34'h3_0003_0003};
    vecs[10] = '{2'd0, 32'hFFFF_BEEF,  3, 2'b00, 2'b10, 2'b00, 1, 32'h0000_BEEF, 3, 0, 34'h0};
    vecs[11] = '{2'd3, 32'd0,          0, 2'b00, 2'b00, 2'b00, 0, 32'h0,        3, 1, 34'h3_0000_0000};
    vecs[12] = '{2'd0, 32'h0000_0F0F,  0, 2'b01, 2'b00, 2'b00, 1, 32'h0000_0F0F, 3, 0, 34'h0};
    vecs[13] = '{2'd1, 32'h0123_4567,  0, 2'b00, 2'b00, 2'b01, 1, 32'h0123_4567, 3, 0, 34'h0};

    do_reset();
    chk("rst read_inc", fifo_read_inc, 0);
    chk("rst write_inc", fifo_write_inc, 0);
    chk("rst write_data", fifo_write_data, 0);
    chk("rst channel", channel, 0);
    chk("rst err_cnt", err_cnt, 0);
    chk("rst we", {config_we_tx, config_we_rx, data_we_tx}, 0);

    for (int k = 0; k < 14; k++) run_vec(vecs[k], k);

    // Busy target stalls the pop until busy drops.
    do_reset();
    rd_status_tx = 2'b01;
    push_in(2'd1, 32'hCAFE_F00D);
    repeat (10) tick();
    chk("busy no pop", n_pops, 0);
    chk("busy no we", n_we, 0);
    rd_status_tx = 2'b00;
    repeat (3) tick();
    chk("busy release we", acc_dwtx, 2'b01);
    chk("busy release bus", cap_bus, 32'hCAFE_F00D);
    chk("busy release pop", n_pops, 1);

    // Simultaneous TX0 config and RX1 (global 3) data/status events.
    do_reset();
    rd_config_tx = {16'h0000, 16'hC0F0};
    rd_data_rx   = {16'hDA7A, 16'h0000};
    rd_status_rx = {16'h5A7E, 16'h0000};
    pulse(2'b01, 2'b00, 2'b00, 2'b10);
    repeat (12) tick();
    chk("evt count", outq.size(), 3);
    if (outq.size() == 3) begin
      chk("evt frame0", outq[0], 34'h0_0000_C0F0);
      chk("evt frame1", outq[1], 34'h1_0003_DA7A);
      chk("evt frame2", outq[2], 34'h2_0003_5A7E);
    end

    // Round-robin resumes after the last serviced index; full blocks pushes.
    do_reset();
    rd_status_tx = 2'b10;
    rd_config_tx = {16'h0000, 16'h1111};
    rd_config_rx = {16'h0000, 16'h0C0C};
    pulse(2'b00, 2'b10, 2'b00, 2'b00);
    repeat (6) tick();
    chk("rr first", outq.size() == 1 ? outq[0] : 34'h0, 34'h2_0001_0001);
    outq.delete();
    clr_mon();
    fifo_write_full = 1'b1;
    pulse(2'b01, 2'b00, 2'b00, 2'b00);
    repeat (3) tick();
    pulse(2'b00, 2'b00, 2'b01, 2'b00);
    repeat (3) tick();
    pulse(2'b00, 2'b10, 2'b00, 2'b00);
    pulse(2'b00, 2'b10, 2'b00, 2'b00);
    repeat (11) tick();
    chk("full no frames", outq.size(), 0);
    chk("full no inc", n_full_push, 0);
    fifo_write_full = 1'b0;
    repeat (12) tick();
    chk("rr count", outq.size(), 3);
    if (outq.size() == 3) begin
      chk("rr frame0", outq[0], 34'h0_0002_0C0C);
      chk("rr frame1", outq[1], 34'h0_0000_1111);
      chk("rr frame2", outq[2], 34'h2_0001_0001);
    end

    // Invalid channel then DATA to an RX channel: two errors, all popped.
    do_reset();
    push_in(2'd3, 32'd2);
    push_in(2'd3, 32'd9);
    push_in(2'd1, 32'h0000_0077);
    repeat (15) tick();
    chk("err2 count", err_cnt, 8'd2);
    chk("err2 pops", n_pops, 3);
    chk("err2 channel", channel, 5'd2);
    chk("err2 no we", n_we, 0);

    // Error counter saturates.
    do_reset();
    for (int i = 0; i < 260; i++) push_in(2'd2, 32'h0);
    repeat (800) tick();
    chk("sat err_cnt", err_cnt, 8'hFF);
    chk("sat pops", n_pops, 260);

    // Reset while a pop/write strobe is in flight.
    do_reset();
    push_in(2'd3, 32'd1);
    repeat (8) tick();
    push_in(2'd0, 32'h0000_7777);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      got = fifo_read_inc;
    end
    chk("mid inflight", got, 1'b1);
    chk("mid we", config_we_tx, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid inc drop", fifo_read_inc, 0);
    chk("mid we drop", config_we_tx, 0);
    chk("mid channel", channel, 0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sl_fifo_bridge_mc.md
Name: sl_fifo_bridge_mc

Overview:
Multi-channel successor of the single-channel FIFO-to-transceiver register bridge. It pops 34-bit command words from a show-ahead inbound FIFO and routes config/data writes to any of TX_COUNT transmitters or RX_COUNT receivers, selected by a channel register. Change events from all channels are captured in sticky pending flags and serviced round-robin. Each event produces a tagged response frame (channel index in the payload) in the outbound FIFO, so events on unselected channels are still reported.

Parameters:
TX_COUNT, 2, number of transmitter channels (1..16); global indices 0..TX_COUNT-1
RX_COUNT, 2, number of receiver channels (1..16); global indices TX_COUNT..TX_COUNT+RX_COUNT-1
CH_W, 5, channel index width; must satisfy 2**CH_W >= TX_COUNT+RX_COUNT
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fifo_read_empty  in  1  inbound FIFO empty
fifo_read_data  in  34  inbound word, show-ahead: [33:32] modifier, [31:0] payload
fifo_read_inc  out  1  inbound pop strobe
fifo_write_full  in  1  outbound FIFO full
fifo_write_data  out  34  outbound word
fifo_write_inc  out  1  outbound push strobe
wr_data_tx  out  32  shared TX data bus
data_we_tx  out  TX_COUNT  one-hot TX data write enable
wr_config_tx  out  16  shared TX config bus
config_we_tx  out  TX_COUNT  one-hot TX config write enable
rd_status_tx  in  TX_COUNT  per-TX busy bit
rd_config_tx  in  16*TX_COUNT  packed TX configs
config_changed_tx, status_changed_tx  in  TX_COUNT  per-TX change pulses
wr_config_rx  out  16  shared RX config bus
config_we_rx  out  RX_COUNT  one-hot RX config write enable
rd_status_rx, rd_config_rx, rd_data_rx  in  16*RX_COUNT  packed; rd_status_rx bit 0 of each lane = busy
config_changed_rx, data_status_changed_rx  in  RX_COUNT  per-RX change pulses
channel  out  CH_W  current channel register
err_cnt  out  ERR_W  saturating protocol error count

Behaviour:
- Single clock domain (clk). Asynchronous active-low reset (rst_n). Reset: all outputs 0, channel=0, all pending flags 0, both FSMs idle.
- Modifier codes: CONFIG=0, DATA=1, STATUS=2, CHANNEL=3.
- Write FSM states: W_IDLE, W_EXEC, W_GAP.
  - W_IDLE with !fifo_read_empty, decode fifo_read_data:
    - CHANNEL: payload < TX_COUNT+RX_COUNT loads channel and sets chan_pend; otherwise channel is unchanged, err_cnt increments and chan_pend is still set.
    - Target channel busy: stay in W_IDLE, no pop (stall).
    - CONFIG to TX/RX, DATA to TX: go to W_EXEC.
    - Any other modifier/target combination: error, err_cnt increments, word is popped.
  - W_EXEC: exactly one cycle; drive the we bit one-hot at channel (or local index channel-TX_COUNT), bus = payload[15:0] or [31:0], fifo_read_inc=1.
  - W_GAP: one cycle, all strobes 0; then return to W_IDLE. This lets empty update, so no double pop.
  - Throughput: one command per 3 cycles.
- Pending flags per channel: cfg_p and st_p (TX status; RX data+status).
  - Set on the input pulse; cleared when the frame is pushed.
  - Set and clear in the same cycle: the flag remains set.
- Read FSM states: R_IDLE, R_PUSH, R_PUSH2.
  - Priority: chan_pend first; otherwise round-robin over global indices, starting one after the last serviced index and wrapping at TX_COUNT+RX_COUNT. Within a channel, cfg_p is served before st_p.
  - Push only when !fifo_write_full. fifo_write_inc is a one-cycle pulse; next grant at earliest 2 cycles later.
- Frame format: [33:32] modifier, [31:16] zero-extended channel index, [15:0] value.
  - CHANNEL frame value = channel.
  - TX config/status: CONFIG/STATUS frame, value = lane, or {15'b0,busy} for TX status.
  - RX st_p: DATA frame (rd_data_rx lane), then R_PUSH2 sends STATUS frame (rd_status_rx lane). R_PUSH2 waits while full; the STATUS value is sampled when pushed.
- err_cnt saturates at all-ones.
- Reset mid-operation: everything returns to reset state. An in-flight pop/push strobe drops within the reset assertion.

Decomposition:
- Package sl_bridge_pkg: modifier codes, frame field positions (HMB=33, LMB=32, CH_LSB=16), state encodings, a frame-assembly function.
- Sub-module sl_rr_arbiter (N requests, one-hot grant, rotating pointer, update on accept).

Test Plan:
- Reset, then CHANNEL word payload 3 (TX_COUNT=2, RX_COUNT=2) -> channel=3; outbound 34'h3_0003_0003; one pop.
- channel=1, CONFIG 16'hA5A5 -> config_we_tx=2'b10 for one cycle, wr_config_tx=A5A5, single fifo_read_inc.
- channel=0 with rd_status_tx[0]=1 and DATA queued -> no pop while busy; busy drops -> data_we_tx=01 and wr_data_tx=payload within 2 cycles.
- config_changed_tx[0] and data_status_changed_rx[1] (global 3) pulsed together -> frames 0_0000_cfg0, then 1_0003_data, then 2_0003_status; no loss.
- fifo_write_full held 20 cycles during event pulses -> no pushes, flags held; frames emitted in round-robin order after release.
- CHANNEL payload 9, then DATA on an RX channel -> err_cnt=2, both words popped, channel unchanged.
